// File: rtl/clock_divider_prog.sv
// clock_divider_prog
// Runtime-programmable divider. It produces a 50%-duty square wave (clk_div)
// and a one-cycle tick in the cycle each new clk_div level appears.
// The half-period divisor arrives over a valid/ready handshake. It is held in
// a shadow register and swapped in only at the falling boundary that closes a
// full period, so no emitted period mixes two divisors. All outputs are
// registered.

module clock_divider_prog #(
  parameter int          CNT_W        = 20,
  parameter int unsigned DEFAULT_HALF = 32'd250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_valid,
  input  logic [CNT_W-1:0] load_div,
  output logic             load_ready,
  output logic             clk_div,
  output logic             tick,
  output logic [CNT_W-1:0] active_div
);

  localparam logic [CNT_W-1:0] DEFAULT_HALF_C = DEFAULT_HALF[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ZERO_C         = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C          = {{(CNT_W-1){1'b0}}, 1'b1};

  // Registered state
  logic [CNT_W-1:0] count_r;
  logic             clk_div_r;
  logic             tick_r;
  logic [CNT_W-1:0] active_div_r;
  logic [CNT_W-1:0] shadow_r;
  logic             pending_r;
  logic             load_ready_r;

  // Next-state values
  logic [CNT_W-1:0] count_s;
  logic             clk_div_s;
  logic             tick_s;
  logic [CNT_W-1:0] active_div_s;
  logic [CNT_W-1:0] shadow_s;
  logic             pending_s;
  logic             load_ready_s;

  // Decoded conditions
  logic             wrap_s;
  logic             xfer_s;
  logic             apply_at_fall_s;

  // Increment the half-period counter. The counter never passes active_div,
  // so the increment cannot wrap past all-ones.
  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] value);
    count_inc = value + ONE_C;
  endfunction

  // Decode the wrap cycle, handshake transfer and falling-boundary apply
  always_comb begin
    wrap_s          = (count_r == active_div_r);
    xfer_s          = load_valid & load_ready_r;
    apply_at_fall_s = wrap_s & clk_div_r & pending_r;
  end

  // Next-state logic for counter, square wave, tick and divisor handshake
  always_comb begin
    count_s      = count_r;
    clk_div_s    = clk_div_r;
    tick_s       = 1'b0;
    active_div_s = active_div_r;
    shadow_s     = shadow_r;
    pending_s    = pending_r;
    load_ready_s = load_ready_r;

    if (en) begin
      if (wrap_s) begin
        // End of a half-period: restart the count and flip the output level
        count_s   = ZERO_C;
        clk_div_s = ~clk_div_r;
        tick_s    = 1'b1;
        if (apply_at_fall_s) begin
          // Falling boundary ends a full period: the new divisor starts cleanly
          active_div_s = shadow_r;
          pending_s    = 1'b0;
          load_ready_s = 1'b1;
        end else begin
          active_div_s = active_div_r;
        end
      end else begin
        count_s = count_inc(count_r);
        tick_s  = 1'b0;
      end
    end else begin
      // Idle: park low with the counter cleared. Nothing is being emitted, so
      // a pending divisor can take effect right away.
      count_s   = ZERO_C;
      clk_div_s = 1'b0;
      tick_s    = 1'b0;
      if (pending_r) begin
        active_div_s = shadow_r;
        pending_s    = 1'b0;
        load_ready_s = 1'b1;
      end else begin
        active_div_s = active_div_r;
      end
    end

    // A transfer needs load_ready=1, so nothing is pending. A transfer can
    // therefore never coincide with an apply, and the new value only arms
    // the next boundary.
    if (xfer_s) begin
      shadow_s     = load_div;
      pending_s    = 1'b1;
      load_ready_s = 1'b0;
    end else begin
      shadow_s = shadow_r;
    end
  end

  // State register with asynchronous reset; any pending load is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r      <= ZERO_C;
      clk_div_r    <= 1'b0;
      tick_r       <= 1'b0;
      active_div_r <= DEFAULT_HALF_C;
      shadow_r     <= ZERO_C;
      pending_r    <= 1'b0;
      load_ready_r <= 1'b1;
    end else begin
      count_r      <= count_s;
      clk_div_r    <= clk_div_s;
      tick_r       <= tick_s;
      active_div_r <= active_div_s;
      shadow_r     <= shadow_s;
      pending_r    <= pending_s;
      load_ready_r <= load_ready_s;
    end
  end

  // Drive outputs straight from registers
  always_comb begin
    clk_div    = clk_div_r;
    tick       = tick_r;
    active_div = active_div_r;
    load_ready = load_ready_r;
  end

endmodule
